// File: rtl/id_dispatch_queue_ctrl.sv
// In-order dual-ported decode queue between Decode and RNDS: up to 2 pushes and 2 pops per cycle.
// Optional same-cycle empty-queue bypass enabled by defining ID_QUEUE_BYPASS_EN.
module id_dispatch_queue_ctrl #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned PAYLOAD_W = 160,
  localparam int unsigned CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in0_valid,
  input  logic [PAYLOAD_W-1:0] in0_data,
  input  logic                 in1_valid,
  input  logic [PAYLOAD_W-1:0] in1_data,
  output logic                 in_ready,
  output logic                 out0_valid,
  output logic [PAYLOAD_W-1:0] out0_data,
  output logic                 out1_valid,
  output logic [PAYLOAD_W-1:0] out1_data,
  input  logic                 out0_issue,
  input  logic                 out1_issue,
  output logic [CNT_W-1:0]     count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PAYLOAD_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]     r_head;
  logic [PTR_W-1:0]     r_tail;
  logic [CNT_W-1:0]     r_count;

  logic                 w_in_ready;
  logic                 w_bypass;
  logic [1:0]           w_nwr;
  logic [PAYLOAD_W-1:0] w_c0;
  logic [PAYLOAD_W-1:0] w_c1;
  logic                 w_out0_valid;
  logic                 w_out1_valid;
  logic [PAYLOAD_W-1:0] w_out0_data;
  logic [PAYLOAD_W-1:0] w_out1_data;
  logic                 w_p0;
  logic                 w_p1;
  logic [1:0]           w_pop;
  logic [1:0]           w_skip;
  logic [1:0]           w_hd_pop;
  logic [1:0]           w_wr_n;
  logic [PAYLOAD_W-1:0] w_wr0;
  logic [PAYLOAD_W-1:0] w_wr1;

  // Readiness, compaction, output selection and pop accounting
  always_comb begin
    w_in_ready = (r_count <= CNT_W'(DEPTH - 2));
`ifdef ID_QUEUE_BYPASS_EN
    w_bypass   = (r_count == '0) && !flush;
`else
    w_bypass   = 1'b0;
`endif
    w_nwr      = w_in_ready ? (2'(in0_valid) + 2'(in1_valid)) : 2'd0;
    w_c0       = in0_valid ? in0_data : in1_data;
    w_c1       = in1_data;

    w_out0_valid = w_bypass ? (w_nwr != 2'd0) : (r_count != '0);
    w_out1_valid = w_bypass ? (w_nwr == 2'd2) : (r_count >= CNT_W'(2));
    w_out0_data  = w_bypass ? w_c0 : r_mem[r_head];
    w_out1_data  = w_bypass ? w_c1 : r_mem[r_head + PTR_W'(1)];

    // out1 may only pop together with out0; unmatched strobes are ignored
    w_p0     = out0_issue && w_out0_valid;
    w_p1     = w_p0 && out1_issue && w_out1_valid;
    w_pop    = 2'(w_p0) + 2'(w_p1);

    w_skip   = w_bypass ? w_pop : 2'd0;
    w_hd_pop = w_bypass ? 2'd0 : w_pop;
    w_wr_n   = w_nwr - w_skip;
    w_wr0    = (w_skip == 2'd1) ? w_c1 : w_c0;
    w_wr1    = w_c1;
  end

  // Pointer, occupancy and storage update; flush overrides everything but reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr_n != 2'd0) r_mem[r_tail] <= w_wr0;
      if (w_wr_n == 2'd2) r_mem[r_tail + PTR_W'(1)] <= w_wr1;
      r_tail  <= r_tail + PTR_W'(w_wr_n);
      r_head  <= r_head + PTR_W'(w_hd_pop);
      r_count <= r_count + CNT_W'(w_wr_n) - CNT_W'(w_hd_pop);
    end
  end

  assign in_ready   = w_in_ready;
  assign out0_valid = w_out0_valid;
  assign out1_valid = w_out1_valid;
  assign out0_data  = w_out0_data;
  assign out1_data  = w_out1_data;
  assign count      = r_count;

  a_issue_order: assert property (@(posedge clk) disable iff (rst) !(out1_issue && !out0_issue))
    else $warning("out1_issue without out0_issue ignored");

endmodule

// File: tb/tb_id_dispatch_queue_ctrl.sv
// Directed bench for id_dispatch_queue_ctrl (DEPTH=8, PAYLOAD_W=160), default or ID_QUEUE_BYPASS_EN build.
module tb_id_dispatch_queue_ctrl;

  localparam int unsigned PW = 160;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in0_valid, in1_valid;
  logic [PW-1:0] in0_data, in1_data;
  logic          in_ready;
  logic          out0_valid, out1_valid;
  logic [PW-1:0] out0_data, out1_data;
  logic          out0_issue, out1_issue;
  logic [3:0]    count;

  int n_checks = 0;
  int n_fail   = 0;

  id_dispatch_queue_ctrl dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in0_valid(in0_valid), .in0_data(in0_data),
    .in1_valid(in1_valid), .in1_data(in1_data),
    .in_ready(in_ready),
    .out0_valid(out0_valid), .out0_data(out0_data),
    .out1_valid(out1_valid), .out1_data(out1_data),
    .out0_issue(out0_issue), .out1_issue(out1_issue),
    .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [PW-1:0] pl(input int n);
    return {5{32'(n)}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush = 0; in0_valid = 0; in1_valid = 0; out0_issue = 0; out1_issue = 0;
    in0_data = '0; in1_data = '0;
  endtask

  task automatic drive(input logic v0, input int d0, input logic v1, input int d1,
                       input logic i0, input logic i1);
    in0_valid = v0; in0_data = pl(d0); in1_valid = v1; in1_data = pl(d1);
    out0_issue = i0; out1_issue = i1;
    #1;
  endtask

  task automatic test_reset();
    rst = 1; idle();
    #12 rst = 0;
    tick();
    n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
    n_checks++; if (out0_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out0_valid: got %b expected 0", out0_valid); end
    n_checks++; if (out1_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out1_valid: got %b expected 0", out1_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_fill();
    for (int k = 0; k < 4; k++) begin
      drive(1, 2*k+1, 1, 2*k+2, 0, 0);
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL fill_ready_%0d: got %b expected 1", k, in_ready); end
      tick();
      n_checks++; if (count !== 4'(2*k+2)) begin n_fail++; $display("FAIL fill_count_%0d: got %0d expected %0d", k, count, 2*k+2); end
    end
    idle(); #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready: got %b expected 0", in_ready); end
    drive(1, 9, 1, 10, 0, 0);
    tick(); idle(); #1;
    n_checks++; if (count !== 4'd8) begin n_fail++; $display("FAIL full_drop_count: got %0d expected 8", count); end
    n_checks++; if (out0_data !== pl(1)) begin n_fail++; $display("FAIL full_out0: got %0h expected %0h", out0_data, pl(1)); end
    n_checks++; if (out1_data !== pl(2)) begin n_fail++; $display("FAIL full_out1: got %0h expected %0h", out1_data, pl(2)); end
  endtask

  task automatic test_drain();
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 0, 0, 1, 1);
      n_checks++; if (count !== 4'(8-2*k)) begin n_fail++; $display("FAIL drain_count_%0d: got %0d expected %0d", k, count, 8-2*k); end
      n_checks++; if (out0_data !== pl(2*k+1)) begin n_fail++; $display("FAIL drain_out0_%0d: got %0h expected %0h", k, out0_data, pl(2*k+1)); end
      n_checks++; if (out1_data !== pl(2*k+2)) begin n_fail++; $display("FAIL drain_out1_%0d: got %0h expected %0h", k, out1_data, pl(2*k+2)); end
      tick();
    end
    idle(); #1;
    n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL drain_final_count: got %0d expected 0", count); end
    n_checks++; if (out0_valid !== 1'b0) begin n_fail++; $display("FAIL drain_out0_valid: got %b expected 0", out0_valid); end
  endtask

  task automatic test_compaction_and_flush();
    drive(1, 11, 1, 12, 0, 0); tick();
    drive(1, 13, 0, 0, 0, 0);  tick();
    n_checks++; if (count !== 4'd3) begin n_fail++; $display("FAIL single0_count: got %0d expected 3", count); end
    drive(0, 0, 1, 14, 0, 0);  tick();
    idle(); #1;
    n_checks++; if (count !== 4'd4) begin n_fail++; $display("FAIL single1_count: got %0d expected 4", count); end
    n_checks++; if (out0_data !== pl(11) || out1_data !== pl(12)) begin n_fail++; $display("FAIL single1_order: got %0h/%0h expected %0h/%0h", out0_data, out1_data, pl(11), pl(12)); end
    drive(1, 15, 0, 0, 0, 0); tick();
    drive(1, 16, 1, 17, 1, 0);
    n_checks++; if (count !== 4'd5 || in_ready !== 1'b1) begin n_fail++; $display("FAIL push_pop_pre: got count %0d ready %b expected 5/1", count, in_ready); end
    tick(); idle(); #1;
    n_checks++; if (count !== 4'd6) begin n_fail++; $display("FAIL push_pop_count: got %0d expected 6", count); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL push_pop_ready: got %b expected 1", in_ready); end
    n_checks++; if (out0_data !== pl(12) || out1_data !== pl(13)) begin n_fail++; $display("FAIL push_pop_head: got %0h/%0h expected %0h/%0h", out0_data, out1_data, pl(12), pl(13)); end
    flush = 1; drive(1, 18, 1, 19, 1, 1);
    tick(); idle(); #1;
    n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL flush_count: got %0d expected 0", count); end
    n_checks++; if (out0_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out0_valid: got %b expected 0", out0_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_bypass();
    drive(1, 31, 1, 32, 1, 1);
`ifdef ID_QUEUE_BYPASS_EN
    n_checks++; if (out0_valid !== 1'b1 || out0_data !== pl(31)) begin n_fail++; $display("FAIL bypass_out0: got %b/%0h expected 1/%0h", out0_valid, out0_data, pl(31)); end
    n_checks++; if (out1_valid !== 1'b1 || out1_data !== pl(32)) begin n_fail++; $display("FAIL bypass_out1: got %b/%0h expected 1/%0h", out1_valid, out1_data, pl(32)); end
    tick(); idle(); #1;
    n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL bypass_count: got %0d expected 0", count); end
`else
    n_checks++; if (out0_valid !== 1'b0) begin n_fail++; $display("FAIL nobypass_out0_valid: got %b expected 0", out0_valid); end
    tick(); idle(); #1;
    n_checks++; if (count !== 4'd2) begin n_fail++; $display("FAIL nobypass_count: got %0d expected 2", count); end
    n_checks++; if (out0_data !== pl(31) || out1_data !== pl(32) || out1_valid !== 1'b1) begin n_fail++; $display("FAIL nobypass_data: got %0h/%0h expected %0h/%0h", out0_data, out1_data, pl(31), pl(32)); end
    flush = 1; tick(); idle(); #1;
`endif
  endtask

  task automatic test_issue_rules();
    drive(1, 41, 1, 42, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 1); tick(); idle(); #1;
    n_checks++; if (count !== 4'd2 || out0_data !== pl(41)) begin n_fail++; $display("FAIL out1_only: got count %0d out0 %0h expected 2/%0h", count, out0_data, pl(41)); end
    drive(0, 0, 0, 0, 1, 0); tick(); idle(); #1;
    n_checks++; if (count !== 4'd1 || out0_data !== pl(42) || out1_valid !== 1'b0) begin n_fail++; $display("FAIL out0_only: got count %0d out0 %0h v1 %b expected 1/%0h/0", count, out0_data, out1_valid, pl(42)); end
    drive(0, 0, 0, 0, 1, 1); tick(); idle(); #1;
    n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL both_one_valid: got %0d expected 0", count); end
    drive(0, 0, 0, 0, 1, 1); tick(); idle(); #1;
    n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL issue_empty: got %0d expected 0", count); end
  endtask

  task automatic test_async_reset();
    drive(1, 51, 1, 52, 0, 0); tick(); idle();
    #2 rst = 1;
    #1;
    n_checks++; if (count !== 4'd0 || out0_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL async_reset: got count %0d v0 %b ready %b expected 0/0/1", count, out0_valid, in_ready); end
    tick(); rst = 0; tick();
    n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL post_reset_count: got %0d expected 0", count); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_compaction_and_flush();
    test_bypass();
    test_issue_rules();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
